// File: rtl/stopwatch_disp.sv
// rtl/stopwatch_disp.sv - multiplexed 7-digit stopwatch display driver
// Scans seven BCD digits with per-frame snapshots, leading-zero blanking and decimal points.
module stopwatch_disp #(
    parameter int DPN = 4,
    parameter int DPL = $clog2(DPN)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] t_mil_0,
    input  logic [3:0] t_mil_1,
    input  logic [3:0] t_mil_2,
    input  logic [3:0] t_sec_0,
    input  logic [3:0] t_sec_1,
    input  logic [3:0] t_min_0,
    input  logic [3:0] t_min_1,
    input  logic       s_run,
    input  logic       s_hld,
    output logic [6:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    // DPN=1 would give a zero-width counter; keep at least one bit
    localparam int CW = (DPL < 1) ? 1 : DPL;
    localparam logic [CW-1:0] CNT_LAST = CW'(DPN - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [3:0]    sh_q [7];
    logic [3:0]    t_in [7];
    logic          last, load;
    logic          blank6, blank5, blank4, blank;
    logic [3:0]    digit;
    logic [6:0]    an_d, seg_d;
    logic          dp_d;

    assign t_in[0] = t_mil_0;
    assign t_in[1] = t_mil_1;
    assign t_in[2] = t_mil_2;
    assign t_in[3] = t_sec_0;
    assign t_in[4] = t_sec_1;
    assign t_in[5] = t_min_0;
    assign t_in[6] = t_min_1;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
        case (v)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    always_comb begin
        last  = (cnt_q == CNT_LAST);
        cnt_d = last ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (last) begin
            idx_d = (idx_q == 3'd6) ? 3'd0 : idx_q + 3'd1;
        end
        if (!en) begin
            cnt_d = '0;
            idx_d = '0;
        end
        // Snapshot at the end of digit 6 so the next frame is tear-free
        load = !en || (last && idx_q == 3'd6);

        blank6 = (sh_q[6] == 4'd0);
        blank5 = blank6 && (sh_q[5] == 4'd0);
        blank4 = blank5 && (sh_q[4] == 4'd0);

        digit = 4'd0;
        blank = 1'b0;
        case (idx_q)
            3'd0: digit = sh_q[0];
            3'd1: digit = sh_q[1];
            3'd2: digit = sh_q[2];
            3'd3: digit = sh_q[3];
            3'd4: begin digit = sh_q[4]; blank = blank4; end
            3'd5: begin digit = sh_q[5]; blank = blank5; end
            3'd6: begin digit = sh_q[6]; blank = blank6; end
            default: ;
        endcase

        an_d  = 7'b1 << idx_q;
        seg_d = blank ? 7'h00 : bcd_to_seg(digit);
        dp_d  = (idx_q == 3'd3) || (idx_q == 3'd5 && s_hld) || (idx_q == 3'd0 && s_run);
        if (!en) begin
            an_d  = '0;
            seg_d = '0;
            dp_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= '0;
            for (int i = 0; i < 7; i++) sh_q[i] <= '0;
            an    <= '0;
            seg   <= '0;
            dp    <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            if (load) begin
                for (int i = 0; i < 7; i++) sh_q[i] <= t_in[i];
            end
            an    <= an_d;
            seg   <= seg_d;
            dp    <= dp_d;
        end
    end

endmodule

// File: tb/tb_stopwatch_disp.sv
// tb/tb_stopwatch_disp.sv - self-checking bench for stopwatch_disp
// Reference model tracks frame position and a per-frame snapshot with plain arithmetic.
module tb_stopwatch_disp;

    localparam int DPN   = 4;
    localparam int FRAME = 7 * DPN;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [3:0] t [7];
    logic       s_run = 1'b0;
    logic       s_hld = 1'b0;
    logic [6:0] an, seg;
    logic       dp;

    int total = 0;
    int bad   = 0;

    // reference model state
    int         pos = 0;
    logic [3:0] snap [7];
    logic [6:0] exp_an, exp_seg;
    logic       exp_dp;

    stopwatch_disp #(.DPN(DPN)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .t_mil_0 (t[0]),
        .t_mil_1 (t[1]),
        .t_mil_2 (t[2]),
        .t_sec_0 (t[3]),
        .t_sec_1 (t[4]),
        .t_min_0 (t[5]),
        .t_min_1 (t[6]),
        .s_run   (s_run),
        .s_hld   (s_hld),
        .an      (an),
        .seg     (seg),
        .dp      (dp)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_seg(input logic [3:0] v);
        case (v)
            4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
            4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
            4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    function automatic bit ref_blank(input int d);
        if (d == 6) return snap[6] == 0;
        if (d == 5) return snap[6] == 0 && snap[5] == 0;
        if (d == 4) return snap[6] == 0 && snap[5] == 0 && snap[4] == 0;
        return 1'b0;
    endfunction

    // Advance the model using the inputs present at this edge
    task automatic model_edge();
        int d;
        if (rst) begin
            exp_an = 0; exp_seg = 0; exp_dp = 0; pos = 0;
            for (int i = 0; i < 7; i++) snap[i] = 0;
        end else if (!en) begin
            exp_an = 0; exp_seg = 0; exp_dp = 0; pos = 0;
            for (int i = 0; i < 7; i++) snap[i] = t[i];
        end else begin
            d       = (pos / DPN) % 7;
            exp_an  = 7'(1 << d);
            exp_seg = ref_blank(d) ? 7'h00 : ref_seg(snap[d]);
            exp_dp  = (d == 3) || (d == 5 && s_hld) || (d == 0 && s_run);
            if (pos % FRAME == FRAME - 1)
                for (int i = 0; i < 7; i++) snap[i] = t[i];
            pos++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_time(input int m1, input int m0, input int s1, input int s0,
                            input int ms2, input int ms1, input int ms0);
        t[6] = 4'(m1); t[5] = 4'(m0); t[4] = 4'(s1); t[3] = 4'(s0);
        t[2] = 4'(ms2); t[1] = 4'(ms1); t[0] = 4'(ms0);
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1;
        tick(); tick();
        total++;
        if ({an, seg, dp} !== 15'h0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0", {an, seg, dp});
        end
    endtask

    task automatic test_scan();
        int hi_run;
        set_time(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0; en = 1'b1;
        tick();
        total++;
        if (an !== 7'h01 || seg !== 7'h3F) begin
            bad++;
            $display("FAIL first_digit got an=%h seg=%h want an=01 seg=3f", an, seg);
        end
        hi_run = 1;
        for (int k = 1; k < 2 * FRAME; k++) begin
            tick();
            total++;
            if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
                bad++;
                $display("FAIL scan k=%0d got=%h want=%h", k, {an, seg, dp}, {exp_an, exp_seg, exp_dp});
            end
            if (an == 7'h01 && k < FRAME) hi_run++;
        end
        total++;
        if (hi_run != DPN) begin
            bad++;
            $display("FAIL digit0_duty got=%0d want=%0d", hi_run, DPN);
        end
    endtask

    task automatic test_patterns();
        int pat [3][9] = '{
            '{0, 0, 0, 7, 1, 2, 3, 0, 0},
            '{0, 0, 5, 9, 8, 7, 6, 0, 1},
            '{1, 0, 2, 12, 4, 5, 6, 1, 1}
        };
        for (int p = 0; p < 3; p++) begin
            set_time(pat[p][0], pat[p][1], pat[p][2], pat[p][3], pat[p][4], pat[p][5], pat[p][6]);
            s_hld = pat[p][7][0]; s_run = pat[p][8][0];
            en = 1'b0; tick(); en = 1'b1;
            for (int k = 0; k < 2 * FRAME; k++) begin
                tick();
                total++;
                if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
                    bad++;
                    $display("FAIL pattern%0d k=%0d got=%h want=%h", p, k, {an, seg, dp}, {exp_an, exp_seg, exp_dp});
                end
            end
        end
        s_hld = 1'b0; s_run = 1'b0;
    endtask

    task automatic test_midframe_change();
        logic [6:0] seg_f1, seg_f2;
        seg_f1 = 0; seg_f2 = 0;
        set_time(0, 0, 0, 0, 1, 2, 3);
        en = 1'b0; tick(); en = 1'b1;
        for (int k = 0; k < 2 * FRAME; k++) begin
            tick();
            total++;
            if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
                bad++;
                $display("FAIL midchange k=%0d got=%h want=%h", k, {an, seg, dp}, {exp_an, exp_seg, exp_dp});
            end
            if (an == 7'h01 && k < FRAME) seg_f1 = seg;
            if (an == 7'h01 && k >= FRAME) seg_f2 = seg;
            if (k == 2 * DPN) t[0] = 4'd4;
        end
        total++;
        if (seg_f1 !== 7'h4F || seg_f2 !== 7'h66) begin
            bad++;
            $display("FAIL midchange_frames got=%h,%h want=4f,66", seg_f1, seg_f2);
        end
    endtask

    task automatic test_en_drop();
        repeat (9) tick();
        set_time(0, 1, 2, 3, 4, 5, 9);
        en = 1'b0; tick();
        total++;
        if ({an, seg, dp} !== 15'h0) begin
            bad++;
            $display("FAIL en_drop got=%h want=0", {an, seg, dp});
        end
        en = 1'b1; tick();
        total++;
        if (an !== 7'h01 || seg !== 7'h6F) begin
            bad++;
            $display("FAIL en_raise got an=%h seg=%h want an=01 seg=6f", an, seg);
        end
    endtask

    task automatic test_midframe_rst();
        repeat (13) tick();
        rst = 1'b1; tick();
        rst = 1'b0;
        for (int k = 0; k < FRAME + 3; k++) begin
            tick();
            total++;
            if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
                bad++;
                $display("FAIL midrst k=%0d got=%h want=%h", k, {an, seg, dp}, {exp_an, exp_seg, exp_dp});
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                for (int i = 0; i < 7; i++)
                    t[i] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            end
            s_run = 1'($urandom);
            s_hld = 1'($urandom);
            en    = ($urandom_range(0, 39) != 0);
            rst   = ($urandom_range(0, 199) == 0);
            tick();
            total++;
            if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
                bad++;
                $display("FAIL random k=%0d got=%h want=%h", k, {an, seg, dp}, {exp_an, exp_seg, exp_dp});
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 7; i++) begin
            t[i] = 4'd0;
            snap[i] = 4'd0;
        end
        test_reset();
        test_scan();
        test_patterns();
        test_midframe_change();
        test_en_drop();
        test_midframe_rst();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
